game_data_holder: RTL and testbench

Upstream data holder for the 8-digit seven-segment display stage. It owns the game state machine, a countdown game timer in whole seconds, and a saturating score accumulator. It drives `score` (14-bit binary, 0–9999) and `g_time` (9-bit binary, 0–511) straight into the display interface, which performs BCD conversion. All outputs are registered.

---
 rtl/game_pkg.sv | 8 +
 rtl/sec_tick_gen.sv | 23 ++
 rtl/game_data_holder.sv | 80 ++++++++
 tb/tb_game_data_holder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and display-facing widths for the game data holder
// Used by game_data_holder and by the seven-segment display interface.
package game_pkg;
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  localparam int SCORE_W = 14;
  localparam int TIME_W = 9;
  localparam int MAX_SCORE_BCD = 9999;
endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: prescaler producing a one-cycle tick every CLK_HZ enabled cycles
// Ports:
//   clk  - clock
//   rst  - synchronous active-high clear of the count
//   en   - count enable; the count holds while low
//   tick - high for one cycle when the count is at CLK_HZ-1 and enabled
module sec_tick_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  logic [CW-1:0] r_cnt;
  assign tick = en && (r_cnt == CW'(CLK_HZ - 1));
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else if (en) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/game_data_holder.sv
// game_data_holder: game FSM, countdown timer and saturating score feeding the display
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - debounced button level; only its rising edge starts a game
//   hit, pts   - one-cycle scoring pulse and the points it carries
//   pause      - level freeze of the running game (only with GAME_DATA_HOLDER_PAUSE_EN)
//   score      - registered binary score, saturating at MAX_SCORE
//   g_time     - registered seconds remaining
//   running    - high while in RUN
//   game_over  - high while in OVER
// Optional feature macro: GAME_DATA_HOLDER_PAUSE_EN adds the pause input.
module game_data_holder
  import game_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int GAME_SECONDS = 300,
  parameter int MAX_SCORE = 9999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic [3:0]         pts,
`ifdef GAME_DATA_HOLDER_PAUSE_EN
  input  logic               pause,
`endif
  output logic [SCORE_W-1:0] score,
  output logic [TIME_W-1:0]  g_time,
  output logic               running,
  output logic               game_over
);
  state_t r_state, w_next;
  logic r_start_q;
  logic w_start_rise, w_reload, w_act, w_tick;
  logic [SCORE_W:0] w_sum;
  logic [SCORE_W-1:0] w_sat;
  assign w_start_rise = start & ~r_start_q;
  assign w_reload = w_start_rise && (r_state != RUN);
`ifdef GAME_DATA_HOLDER_PAUSE_EN
  assign w_act = (r_state == RUN) && !pause;
`else
  assign w_act = (r_state == RUN);
`endif
  // The reload also clears the prescaler so each game's first second is a full one.
  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk (clk),
    .rst (rst | w_reload),
    .en  (w_act),
    .tick(w_tick)
  );
  assign w_sum = {1'b0, score} + {{(SCORE_W - 3){1'b0}}, pts};
  assign w_sat = (w_sum > (SCORE_W + 1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : w_sum[SCORE_W-1:0];
  always_comb begin
    w_next = r_state;
    if (w_reload) w_next = RUN;
    else if (w_tick && g_time == TIME_W'(1)) w_next = OVER;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      score     <= '0;
      g_time    <= TIME_W'(GAME_SECONDS);
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_q <= start;
      running   <= (w_next == RUN);
      game_over <= (w_next == OVER);
      if (w_reload) begin
        score  <= '0;
        g_time <= TIME_W'(GAME_SECONDS);
      end else begin
        if (w_act && hit) score <= w_sat;
        if (w_tick) g_time <= g_time - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_game_data_holder.sv
// tb_game_data_holder: table-driven check of game_data_holder with CLK_HZ=10, GAME_SECONDS=3
module tb_game_data_holder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic hit = 1'b0;
  logic [3:0] pts = 4'd0;
`ifdef GAME_DATA_HOLDER_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic [13:0] score, score2;
  logic [8:0] g_time, g_time2;
  logic running, running2, game_over, game_over2;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  game_data_holder #(.CLK_HZ(10), .GAME_SECONDS(3), .MAX_SCORE(9999)) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .pts(pts),
`ifdef GAME_DATA_HOLDER_PAUSE_EN
    .pause(pause),
`endif
    .score(score), .g_time(g_time), .running(running), .game_over(game_over)
  );

  game_data_holder #(.CLK_HZ(10), .GAME_SECONDS(3), .MAX_SCORE(20)) dut_cap (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .pts(pts),
`ifdef GAME_DATA_HOLDER_PAUSE_EN
    .pause(pause),
`endif
    .score(score2), .g_time(g_time2), .running(running2), .game_over(game_over2)
  );

  typedef struct {
    logic       st;
    logic       ht;
    logic [3:0] pt;
    int         n;
    int         sc;
    int         sc_cap;
    int         tm;
    logic       ru;
    logic       ov;
  } vec_t;

  vec_t v[22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int sc, input int sc_cap, input int tm, input logic ru, input logic ov);
    chk({nm, " score"}, 32'(score), sc);
    chk({nm, " score_cap"}, 32'(score2), sc_cap);
    chk({nm, " g_time"}, 32'(g_time), tm);
    chk({nm, " running"}, 32'(running), 32'(ru));
    chk({nm, " game_over"}, 32'(game_over), 32'(ov));
  endtask

  initial begin
    // {start, hit, pts, cycles, score, capped score, g_time, running, game_over}
    v[0]  = '{1'b0, 1'b0, 4'd0,  50, 0,  0,  3, 1'b0, 1'b0};
    v[1]  = '{1'b1, 1'b0, 4'd0,  1,  0,  0,  3, 1'b1, 1'b0};
    v[2]  = '{1'b1, 1'b1, 4'd15, 1,  15, 15, 3, 1'b1, 1'b0};
    v[3]  = '{1'b1, 1'b1, 4'd7,  1,  22, 20, 3, 1'b1, 1'b0};
    v[4]  = '{1'b1, 1'b1, 4'd0,  1,  22, 20, 3, 1'b1, 1'b0};
    v[5]  = '{1'b1, 1'b0, 4'd0,  6,  22, 20, 3, 1'b1, 1'b0};
    v[6]  = '{1'b1, 1'b0, 4'd0,  1,  22, 20, 2, 1'b1, 1'b0};
    v[7]  = '{1'b1, 1'b0, 4'd0,  9,  22, 20, 2, 1'b1, 1'b0};
    v[8]  = '{1'b1, 1'b0, 4'd0,  1,  22, 20, 1, 1'b1, 1'b0};
    v[9]  = '{1'b1, 1'b0, 4'd0,  8,  22, 20, 1, 1'b1, 1'b0};
    v[10] = '{1'b1, 1'b1, 4'd5,  1,  27, 20, 1, 1'b1, 1'b0};
    v[11] = '{1'b1, 1'b1, 4'd3,  1,  30, 20, 0, 1'b0, 1'b1};
    v[12] = '{1'b1, 1'b1, 4'd4,  5,  30, 20, 0, 1'b0, 1'b1};
    v[13] = '{1'b0, 1'b0, 4'd0,  3,  30, 20, 0, 1'b0, 1'b1};
    v[14] = '{1'b1, 1'b1, 4'd9,  1,  0,  0,  3, 1'b1, 1'b0};
    v[15] = '{1'b1, 1'b1, 4'd9,  1,  9,  9,  3, 1'b1, 1'b0};
    v[16] = '{1'b1, 1'b1, 4'd9,  1,  18, 18, 3, 1'b1, 1'b0};
    v[17] = '{1'b1, 1'b1, 4'd9,  1,  27, 20, 3, 1'b1, 1'b0};
    v[18] = '{1'b1, 1'b1, 4'd1,  1,  28, 20, 3, 1'b1, 1'b0};
    v[19] = '{1'b1, 1'b0, 4'd0,  5,  28, 20, 3, 1'b1, 1'b0};
    v[20] = '{1'b1, 1'b0, 4'd0,  1,  28, 20, 2, 1'b1, 1'b0};
    v[21] = '{1'b1, 1'b1, 4'd12, 1,  40, 20, 2, 1'b1, 1'b0};
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_all("reset", 0, 0, 3, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      start = v[i].st;
      hit = v[i].ht;
      pts = v[i].pt;
      step();
      hit = 1'b0;
      for (int k = 1; k < v[i].n; k++) step();
      chk_all($sformatf("v%0d", i), v[i].sc, v[i].sc_cap, v[i].tm, v[i].ru, v[i].ov);
    end
    start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("midrun_rst", 0, 0, 3, 1'b0, 1'b0);
    step();
    step();
    chk_all("post_rst_idle", 0, 0, 3, 1'b0, 1'b0);
`ifdef GAME_DATA_HOLDER_PAUSE_EN
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    pause = 1'b1;
    hit = 1'b1;
    pts = 4'd5;
    step();
    hit = 1'b0;
    for (int k = 0; k < 24; k++) step();
    chk_all("paused", 0, 0, 3, 1'b1, 1'b0);
    pause = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk_all("pause_before_tick", 0, 0, 3, 1'b1, 1'b0);
    step();
    chk_all("pause_tick", 0, 0, 2, 1'b1, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
